// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: the per-beat mode encoding
// and its width.
package act_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ACT_RELU  = 2'd0,
    ACT_HTANH = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_PASS  = 2'd3
  } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// One activation lane: pre-shift, nonlinearity, clamp to the output range,
// and a flag telling whether the clamp altered the value.
module act_lane
  import act_pkg::*;
#(
  parameter int IWID = 14,
  parameter int OWID = 10,
  parameter int SHR  = 2,
  parameter int LSH  = 3
) (
  input  logic [IWID-1:0] x,
  input  act_mode_e       mode,
  output logic [OWID-1:0] y,
  output logic            clip
);

  // Signed output range and unsigned RELU ceiling, all expressed at input width.
  localparam logic signed [IWID-1:0] S_MAX = IWID'((1 << (OWID - 1)) - 1);
  localparam logic signed [IWID-1:0] S_MIN = ~S_MAX;
  localparam logic signed [IWID-1:0] U_MAX = IWID'((1 << OWID) - 1);

  logic signed [IWID-1:0] s;
  logic signed [IWID-1:0] t;

  assign s = $signed(x) >>> SHR;

  // NOTE: every output gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    y    = '0;
    clip = 1'b0;
    t    = s;
    if (mode == ACT_RELU) begin
      // Zeroing a negative is the nonlinearity itself, so only the top clamps.
      if (s > U_MAX) begin
        y    = '1;
        clip = 1'b1;
      end else if (!s[IWID-1]) begin
        y = s[OWID-1:0];
      end
    end else begin
      if (mode == ACT_LEAKY && s[IWID-1]) begin
        t = s >>> LSH;
      end
      if (t > S_MAX) begin
        y    = S_MAX[OWID-1:0];
        clip = 1'b1;
      end else if (t < S_MIN) begin
        y    = S_MIN[OWID-1:0];
        clip = 1'b1;
      end else begin
        y = t[OWID-1:0];
      end
    end
  end

endmodule

// File: rtl/act_pipe.sv
// Two-stage elastic activation pipeline over NCH lanes with a saturating
// count of clipped lane-samples.
module act_pipe
  import act_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int IWID = 14,
  parameter int OWID = 10,
  parameter int SHR  = 2,
  parameter int LSH  = 3,
  parameter int CWID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [MODE_W-1:0]   i_mode,
  input  logic [NCH*IWID-1:0] iData,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [NCH*OWID-1:0] oData,
  input  logic                clip_clr,
  output logic [CWID-1:0]     clip_cnt
);

  localparam int SUM_W = $clog2(NCH + 1);

  logic                s1_valid;
  logic                s2_valid;
  logic                s2_adv;
  logic                s1_move;
  logic                in_xfer;
  logic [NCH*IWID-1:0] s1_data;
  act_mode_e           s1_mode;
  logic [NCH*OWID-1:0] lane_y;
  logic [NCH-1:0]      lane_clip;
  logic [SUM_W-1:0]    clip_sum;
  logic [CWID:0]       cnt_sum;

  // Ready depends only on pipeline state and o_ready, never on i_valid.
  assign s2_adv  = !s2_valid || o_ready;
  assign s1_move = s1_valid && s2_adv;
  assign i_ready = !s1_valid || s2_adv;
  assign in_xfer = i_valid && i_ready;
  assign o_valid = s2_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (i_ready) begin
      s1_valid <= i_valid;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid, so it carries no
  // reset and stays a plain enabled register.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_data <= iData;
      s1_mode <= act_mode_e'(i_mode);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    act_lane #(
      .IWID (IWID),
      .OWID (OWID),
      .SHR  (SHR),
      .LSH  (LSH)
    ) u_lane (
      .x    (s1_data[k*IWID +: IWID]),
      .mode (s1_mode),
      .y    (lane_y[k*OWID +: OWID]),
      .clip (lane_clip[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      oData    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        oData <= lane_y;
      end
    end
  end

  always_comb begin
    clip_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      clip_sum = clip_sum + SUM_W'(lane_clip[k]);
    end
  end

  // One extra bit catches the carry out; the increment never exceeds NCH.
  assign cnt_sum = {1'b0, clip_cnt} + (CWID + 1)'(clip_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (clip_clr) begin
      clip_cnt <= '0;
    end else if (s1_move) begin
      clip_cnt <= cnt_sum[CWID] ? '1 : cnt_sum[CWID-1:0];
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Directed bench for act_pipe: per-mode vectors, counter saturation and clear,
// per-beat mode capture, a stalled stream and reset with beats in flight.
module tb_act_pipe;

  localparam int NCH  = 4;
  localparam int IWID = 14;
  localparam int OWID = 10;

  logic                clk;
  logic                rst;
  logic                i_valid;
  logic                i_ready;
  logic [1:0]          i_mode;
  logic [NCH*IWID-1:0] idata;
  logic                o_valid;
  logic                o_ready;
  logic [NCH*OWID-1:0] odata;
  logic                clip_clr;
  logic [15:0]         clip_cnt;

  logic                i_ready_s;
  logic                o_valid_s;
  logic [NCH*OWID-1:0] odata_s;
  logic [3:0]          clip_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  act_pipe #(.NCH(NCH), .IWID(IWID), .OWID(OWID), .SHR(2), .LSH(3), .CWID(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode),
    .iData(idata), .o_valid(o_valid), .o_ready(o_ready), .oData(odata),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt)
  );

  act_pipe #(.NCH(NCH), .IWID(IWID), .OWID(OWID), .SHR(2), .LSH(3), .CWID(4)) dut_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_s), .i_mode(i_mode),
    .iData(idata), .o_valid(o_valid_s), .o_ready(o_ready), .oData(odata_s),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*IWID-1:0] pin(input int a, input int b, input int c, input int d);
    logic [NCH*IWID-1:0] r;
    r[0*IWID +: IWID] = a[IWID-1:0];
    r[1*IWID +: IWID] = b[IWID-1:0];
    r[2*IWID +: IWID] = c[IWID-1:0];
    r[3*IWID +: IWID] = d[IWID-1:0];
    return r;
  endfunction

  function automatic logic [NCH*OWID-1:0] pout(input int a, input int b, input int c, input int d);
    logic [NCH*OWID-1:0] r;
    r[0*OWID +: OWID] = a[OWID-1:0];
    r[1*OWID +: OWID] = b[OWID-1:0];
    r[2*OWID +: OWID] = c[OWID-1:0];
    r[3*OWID +: OWID] = d[OWID-1:0];
    return r;
  endfunction

  // Stream beat b, lane k carries 4*v with v = 8b+k-80; PASS mode returns v.
  function automatic logic [NCH*IWID-1:0] stream_in(input int b);
    return pin(4*(8*b-80), 4*(8*b-79), 4*(8*b-78), 4*(8*b-77));
  endfunction

  function automatic logic [NCH*OWID-1:0] stream_out(input int b);
    return pout(8*b-80, 8*b-79, 8*b-78, 8*b-77);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; checks the two-cycle latency and result.
  task automatic beat_check(input string tag, input logic [1:0] m, input logic [NCH*IWID-1:0] d,
                            input logic [NCH*OWID-1:0] exp_y, input int exp_c, input int exp_cs);
    i_valid = 1'b1;
    i_mode  = m;
    idata   = d;
    @(negedge clk);
    check({tag, "_iready"}, 64'(i_ready), 64'd1);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat"}, 64'(o_valid), 64'd0);
    tick();
    @(negedge clk);
    check({tag, "_ovalid"}, 64'(o_valid), 64'd1);
    check({tag, "_odata"}, 64'(odata), 64'(exp_y));
    check({tag, "_odata_s"}, 64'(odata_s), 64'(exp_y));
    check({tag, "_cnt"}, 64'(clip_cnt), 64'(exp_c));
    check({tag, "_cnt_s"}, 64'(clip_cnt_s), 64'(exp_cs));
    tick();
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic prev_stall;
    logic [NCH*OWID-1:0] prev_data;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; clip_clr = 1'b0;
    i_mode = 2'd0; idata = '0;

    repeat (2) @(negedge clk);
    check("rst_ovalid", 64'(o_valid), 64'd0);
    check("rst_odata", 64'(odata), 64'd0);
    check("rst_cnt", 64'(clip_cnt), 64'd0);
    check("rst_cnt_s", 64'(clip_cnt_s), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel_iready", 64'(i_ready), 64'd1);
    tick();

    beat_check("relu",  2'd0, pin(400, -400, 4096, 8191),   pout(100, 0, 1023, 1023), 2, 2);
    beat_check("htanh", 2'd1, pin(8191, -8192, -400, 0),    pout(511, -512, -100, 0), 4, 4);
    beat_check("leaky", 2'd2, pin(-400, 400, -8192, 0),     pout(-13, 100, -256, 0),  4, 4);
    beat_check("pass",  2'd3, pin(-4, 2044, -2052, 2048),   pout(-1, 511, -512, 511), 6, 6);
    beat_check("clip4a", 2'd1, pin(8191, 8191, -8192, -8192), pout(511, 511, -512, -512), 10, 10);
    beat_check("clip4b", 2'd1, pin(8191, 8191, -8192, -8192), pout(511, 511, -512, -512), 14, 14);
    beat_check("sat",   2'd1, pin(8191, 8191, -8192, -8192), pout(511, 511, -512, -512), 18, 15);

    // Clear lands in the cycle the clipping beat moves into stage 2.
    i_valid = 1'b1; i_mode = 2'd1; idata = pin(8191, 8191, -8192, -8192);
    tick();
    i_valid = 1'b0;
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    @(negedge clk);
    check("clr_ovalid", 64'(o_valid), 64'd1);
    check("clr_cnt", 64'(clip_cnt), 64'd0);
    check("clr_cnt_s", 64'(clip_cnt_s), 64'd0);
    tick();

    // Back-to-back beats with different modes keep their own mode.
    i_valid = 1'b1; i_mode = 2'd0; idata = pin(-400, 400, -8192, 0);
    tick();
    i_mode = 2'd2;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("mode_a_ovalid", 64'(o_valid), 64'd1);
    check("mode_a_odata", 64'(odata), 64'(pout(0, 100, 0, 0)));
    tick();
    @(negedge clk);
    check("mode_b_ovalid", 64'(o_valid), 64'd1);
    check("mode_b_odata", 64'(odata), 64'(pout(-13, 100, -256, 0)));
    check("mode_cnt", 64'(clip_cnt), 64'd0);
    tick();

    // Stream of 20 PASS beats with random back-pressure.
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    i_mode = 2'd3;
    while (recv < 20 && cyc < 400) begin
      i_valid = (sent < 20);
      idata   = stream_in(sent);
      o_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("stream_iready_c%0d", cyc), 64'(i_ready),
            64'(!((sent - recv) == 2 && !o_ready)));
      if (prev_stall) begin
        check($sformatf("stall_valid_c%0d", cyc), 64'(o_valid), 64'd1);
        check($sformatf("stall_data_c%0d", cyc), 64'(odata), 64'(prev_data));
      end
      if (o_valid && o_ready) begin
        check($sformatf("stream_out%0d", recv), 64'(odata), 64'(stream_out(recv)));
        recv++;
      end
      if (i_valid && i_ready) sent++;
      prev_stall = o_valid && !o_ready;
      prev_data  = odata;
      cyc++;
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    check("stream_count", 64'(recv), 64'd20);
    repeat (3) tick();
    @(negedge clk);
    check("stream_no_extra", 64'(o_valid), 64'd0);
    tick();

    // Reset with two beats in flight.
    i_valid = 1'b1; i_mode = 2'd1; idata = pin(8191, 0, 0, 0);
    tick();
    idata = pin(-8192, 0, 0, 0);
    tick();
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ovalid", 64'(o_valid), 64'd0);
    check("arst_odata", 64'(odata), 64'd0);
    check("arst_cnt", 64'(clip_cnt), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_ovalid%0d", i), 64'(o_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("post_rst_iready", 64'(i_ready), 64'd1);
    check("post_rst_iready_s", 64'(i_ready_s), 64'd1);
    check("post_rst_ovalid_s", 64'(o_valid_s), 64'd0);
    check("post_rst_cnt", 64'(clip_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_pipe.md
ACT_PIPE -- requirements
Module: act_pipe

Interface
REQ-001 Parameter NCH, default 4, number of parallel channels (lanes), >=1.
REQ-002 Parameter IWID, default 14, signed two's-complement input width per lane.
REQ-003 Parameter OWID, default 10, output width per lane, OWID < IWID.
REQ-004 Parameter SHR, default 2, arithmetic right-shift applied to every input before activation, 0..IWID-OWID.
REQ-005 Parameter LSH, default 3, extra arithmetic right-shift for negative values in LEAKY mode.
REQ-006 Parameter CWID, default 16, width of the clip counter.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 i_valid  in  1  input beat valid.
REQ-010 i_ready  out  1  block can accept a beat this cycle.
REQ-011 i_mode  in  2  activation mode, carried with the beat: 0 RELU, 1 HTANH, 2 LEAKY, 3 PASS.
REQ-012 iData  in  NCH*IWID  packed lanes, lane k at bits [k*IWID +: IWID].
REQ-013 o_valid  out  1  output beat valid.
REQ-014 o_ready  in  1  downstream accepts beat.
REQ-015 oData  out  NCH*OWID  packed results, same lane ordering.
REQ-016 clip_clr  in  1  synchronous clear of clip counter.
REQ-017 clip_cnt  out  CWID  saturating count of clipped lane-samples.

Function
REQ-018 Per lane: s = iData_k >>> SHR (arithmetic, sign-preserving, floor).
REQ-019 RELU: y = 0 if s<0, else min(s, 2^OWID-1), output unsigned.
REQ-020 HTANH: y = s clamped to [-2^(OWID-1), 2^(OWID-1)-1], output signed.
REQ-021 LEAKY: t = s if s>=0 else s >>> LSH; y = t clamped as HTANH, output signed.
REQ-022 PASS: y = s clamped as HTANH (no nonlinearity).
REQ-023 A lane is "clipped" when the clamp changed its value; RELU zeroing of a negative is not a clip.
REQ-024 Two-register pipeline: stage 1 registers iData and i_mode on transfer (i_valid & i_ready); stage 2 registers computed oData; latency 2 cycles from input transfer to o_valid with no stall.
REQ-025 Stage 2 advances when !s2_valid | o_ready; stage 1 advances into stage 2 under the same condition; i_ready = !s1_valid | (s2 advance).
REQ-026 Throughput one beat per cycle when o_ready held high; no beat dropped or duplicated under any o_ready pattern.
REQ-027 While o_valid & !o_ready, oData and o_valid SHALL remain stable.
REQ-028 i_ready SHALL not depend combinationally on i_valid.
REQ-029 clip_cnt increments by the number of clipped lanes (0..NCH) of a beat at the cycle that beat moves stage 1 -> stage 2; saturates at 2^CWID-1.
REQ-030 clip_clr in the same cycle as an increment: clear wins, counter = 0, that beat's clips discarded.
REQ-031 i_mode change between beats takes effect per beat; beats in flight keep their captured mode.

Reset
REQ-032 rst asserted: o_valid=0, internal stage valids=0, clip_cnt=0, oData=0, i_ready=1 after release, asynchronously on assertion.
REQ-033 Reset mid-transfer discards all in-flight beats; no output beat produced for them after release.
REQ-034 Data registers of stage 1 need no reset; valid bits and counter do.

Structure
REQ-035 Shared package act_pkg holds mode enum (ACT_RELU, ACT_HTANH, ACT_LEAKY, ACT_PASS) and the mode width constant.
REQ-036 One combinational sub-module act_lane (IWID, OWID, SHR, LSH) computes y and clip flag for one lane; act_pipe instantiates NCH copies between stage 1 and stage 2.

Verification (NCH=4, IWID=14, OWID=10, SHR=2, LSH=3)
REQ-037 RELU lanes {400, -400, 4096, 8191}, o_ready=1 -> two cycles later oData lanes {100, 0, 1023, 1023}, clip_cnt=2.
REQ-038 HTANH lanes {8191, -8192, -400, 0} -> {511, -512, -100, 0}, clip_cnt +2.
REQ-039 LEAKY lanes {-400, 400, -8192, 0} -> {-13, 100, -256, 0}, clip_cnt +0.
REQ-040 Stream of 20 beats with o_ready toggled random 50% -> all 20 outputs in order, oData stable during every stall, i_ready low only when both stages full and o_ready low.
REQ-041 clip_cnt forced near saturation (CWID=4, count 14) then beat with 4 clips -> 15; clip_clr coincident with a clipping beat -> 0.
REQ-042 rst asserted with two beats in flight -> o_valid falls immediately, no output after release, clip_cnt=0.
